// File: rtl/axi_stream_header_arbiter.sv
// Two-source round-robin arbiter in front of a header-insert datapath.
// A granted source sends one header, then its packet body; the grant is held until the last beat.
module axi_stream_header_arbiter #(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
   parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   s_valid_in,
   input  logic [2*DATA_WIDTH-1:0]      s_data_in,
   input  logic [2*DATA_BYTE_WIDTH-1:0] s_keep_in,
   input  logic [1:0]                   s_last_in,
   output logic [1:0]                   s_ready_in,
   input  logic [1:0]                   s_valid_insert,
   input  logic [2*DATA_WIDTH-1:0]      s_data_insert,
   input  logic [2*DATA_BYTE_WIDTH-1:0] s_keep_insert,
   input  logic [2*BYTE_CNT_WIDTH-1:0]  s_byte_insert_cnt,
   output logic [1:0]                   s_ready_insert,
   output logic                         valid_in,
   output logic [DATA_WIDTH-1:0]        data_in,
   output logic [DATA_BYTE_WIDTH-1:0]   keep_in,
   output logic                         last_in,
   input  logic                         ready_in,
   output logic                         valid_insert,
   output logic [DATA_WIDTH-1:0]        data_insert,
   output logic [DATA_BYTE_WIDTH-1:0]   keep_insert,
   output logic [BYTE_CNT_WIDTH-1:0]    byte_insert_cnt,
   input  logic                         ready_insert,
   output logic                         busy,
   output logic                         grant,
   output logic [15:0]                  pkt_cnt0,
   output logic [15:0]                  pkt_cnt1
);

   typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

   state_t state;
   logic   last_grant;
   logic   hdr_fire;
   logic   last_fire;

   assign busy      = (state != IDLE);
   assign hdr_fire  = (state == HDR) && valid_insert && ready_insert;
   assign last_fire = (state == BODY) && valid_in && ready_in && last_in;

   // Each channel is a pure mux of the granted source, live only in its own phase.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
      s_ready_in      = '0;
      s_ready_insert  = '0;
      valid_in        = 1'b0;
      data_in         = '0;
      keep_in         = '0;
      last_in         = 1'b0;
      valid_insert    = 1'b0;
      data_insert     = '0;
      keep_insert     = '0;
      byte_insert_cnt = '0;
      case (state)
         HDR: begin
            valid_insert           = s_valid_insert[grant];
            data_insert            = s_data_insert[grant*DATA_WIDTH +: DATA_WIDTH];
            keep_insert            = s_keep_insert[grant*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH];
            byte_insert_cnt        = s_byte_insert_cnt[grant*BYTE_CNT_WIDTH +: BYTE_CNT_WIDTH];
            s_ready_insert[grant]  = ready_insert;
         end
         BODY: begin
            valid_in           = s_valid_in[grant];
            data_in            = s_data_in[grant*DATA_WIDTH +: DATA_WIDTH];
            keep_in            = s_keep_in[grant*DATA_BYTE_WIDTH +: DATA_BYTE_WIDTH];
            last_in            = s_last_in[grant];
            s_ready_in[grant]  = ready_in;
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         pkt_cnt0   <= 16'd0;
         pkt_cnt1   <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|s_valid_insert) begin
                  // On a tie the source that did not win last time goes next.
                  grant <= (&s_valid_insert) ? ~last_grant : s_valid_insert[1];
                  state <= HDR;
               end
            end
            HDR: begin
               if (hdr_fire) state <= BODY;
            end
            BODY: begin
               if (last_fire) begin
                  state      <= IDLE;
                  last_grant <= grant;
                  if (grant) pkt_cnt1 <= pkt_cnt1 + 16'd1;
                  else       pkt_cnt0 <= pkt_cnt0 + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Scoreboard bench: source drivers queue expected headers/beats, a negedge monitor
// checks forwarding, arbitration order, readiness, counters and reset behaviour.
module tb_axi_stream_header_arbiter;

   localparam int DW  = 32;
   localparam int DBW = 4;
   localparam int BCW = 2;

   typedef struct {
      logic [DW-1:0]  data;
      logic [DBW-1:0] keep;
      logic           last;
      logic [BCW-1:0] cnt;
   } item_t;

   typedef enum {M_IDLE, M_HDR, M_BODY} mphase_t;

   logic clk, rst;
   logic [1:0]       s_valid_in, s_last_in, s_ready_in;
   logic [2*DW-1:0]  s_data_in, s_data_insert;
   logic [2*DBW-1:0] s_keep_in, s_keep_insert;
   logic [1:0]       s_valid_insert, s_ready_insert;
   logic [2*BCW-1:0] s_byte_insert_cnt;
   logic             valid_in, last_in, ready_in;
   logic [DW-1:0]    data_in, data_insert;
   logic [DBW-1:0]   keep_in, keep_insert;
   logic             valid_insert, ready_insert;
   logic [BCW-1:0]   byte_insert_cnt;
   logic             busy, grant;
   logic [15:0]      pkt_cnt0, pkt_cnt1;

   // Per-source driver state.
   logic           sv_in [2];
   logic [DW-1:0]  sd_in [2];
   logic [DBW-1:0] sk_in [2];
   logic           sl_in [2];
   logic           svi   [2];
   logic [DW-1:0]  sdi   [2];
   logic [DBW-1:0] ski   [2];
   logic [BCW-1:0] sci   [2];

   assign s_valid_in        = {sv_in[1], sv_in[0]};
   assign s_data_in         = {sd_in[1], sd_in[0]};
   assign s_keep_in         = {sk_in[1], sk_in[0]};
   assign s_last_in         = {sl_in[1], sl_in[0]};
   assign s_valid_insert    = {svi[1], svi[0]};
   assign s_data_insert     = {sdi[1], sdi[0]};
   assign s_keep_insert     = {ski[1], ski[0]};
   assign s_byte_insert_cnt = {sci[1], sci[0]};

   axi_stream_header_arbiter #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
      .s_last_in(s_last_in), .s_ready_in(s_ready_in),
      .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert),
      .s_keep_insert(s_keep_insert), .s_byte_insert_cnt(s_byte_insert_cnt),
      .s_ready_insert(s_ready_insert),
      .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
      .ready_in(ready_in),
      .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
      .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
      .busy(busy), .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard queues, filled by drivers, drained by the monitor.
   item_t hq0[$], hq1[$], bq0[$], bq1[$];
   int    grant_log[$];

   mphase_t     ph;
   bit          m_g, m_last;
   logic [15:0] m_cnt [2];
   bit          sink_rand;

   // ---------------- monitor / reference model ----------------
   mphase_t ph_n;
   item_t   mon_e;
   always @(negedge clk) begin
      if (rst) begin
         check("rst_busy",  busy, 0);
         check("rst_grant", grant, 0);
         check("rst_ready", {s_ready_in, s_ready_insert}, 0);
         check("rst_valid", {valid_in, valid_insert}, 0);
         check("rst_cnt",   {pkt_cnt1, pkt_cnt0}, 0);
         ph = M_IDLE; m_last = 1'b1; m_g = 1'b0;
         m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
         hq0.delete(); hq1.delete(); bq0.delete(); bq1.delete();
      end else begin
         ph_n = ph;
         check("busy", busy, ph != M_IDLE);
         check("pkt_cnt0", pkt_cnt0, m_cnt[0]);
         check("pkt_cnt1", pkt_cnt1, m_cnt[1]);
         case (ph)
            M_IDLE: begin
               check("idle_ready", {s_ready_in, s_ready_insert}, 0);
               check("idle_hdr_out", {valid_insert, keep_insert, byte_insert_cnt, data_insert}, 0);
               check("idle_str_out", {valid_in, last_in, keep_in, data_in}, 0);
               if (s_valid_insert != 2'b00) begin
                  m_g  = (s_valid_insert == 2'b11) ? ~m_last : s_valid_insert[1];
                  ph_n = M_HDR;
               end
            end
            M_HDR: begin
               check("hdr_grant", grant, m_g);
               check("hdr_s_ready_insert", s_ready_insert, ready_insert ? (2'b01 << m_g) : 2'b00);
               check("hdr_s_ready_in", s_ready_in, 0);
               check("hdr_str_out", {valid_in, last_in, keep_in, data_in}, 0);
               check("hdr_fwd", {valid_insert, keep_insert, byte_insert_cnt, data_insert},
                     {svi[m_g], ski[m_g], sci[m_g], sdi[m_g]});
               if (svi[m_g] && ready_insert) begin
                  check("hdr_q_nonempty", (m_g ? hq1.size() : hq0.size()) > 0, 1);
                  if ((m_g ? hq1.size() : hq0.size()) > 0) begin
                     mon_e = m_g ? hq1.pop_front() : hq0.pop_front();
                     check("hdr_data", {keep_insert, byte_insert_cnt, data_insert},
                           {mon_e.keep, mon_e.cnt, mon_e.data});
                  end
                  grant_log.push_back(int'(m_g));
                  ph_n = M_BODY;
               end
            end
            M_BODY: begin
               check("body_grant", grant, m_g);
               check("body_s_ready_in", s_ready_in, ready_in ? (2'b01 << m_g) : 2'b00);
               check("body_s_ready_insert", s_ready_insert, 0);
               check("body_hdr_out", {valid_insert, keep_insert, byte_insert_cnt, data_insert}, 0);
               check("body_fwd", {valid_in, last_in, keep_in, data_in},
                     {sv_in[m_g], sl_in[m_g], sk_in[m_g], sd_in[m_g]});
               if (sv_in[m_g] && ready_in) begin
                  check("beat_q_nonempty", (m_g ? bq1.size() : bq0.size()) > 0, 1);
                  if ((m_g ? bq1.size() : bq0.size()) > 0) begin
                     mon_e = m_g ? bq1.pop_front() : bq0.pop_front();
                     check("beat_data", {last_in, keep_in, data_in}, {mon_e.last, mon_e.keep, mon_e.data});
                  end
                  if (sl_in[m_g]) begin
                     m_cnt[m_g] = m_cnt[m_g] + 16'd1;
                     m_last     = m_g;
                     ph_n       = M_IDLE;
                  end
               end
            end
            default: ;
         endcase
         ph = ph_n;
      end
   end

   // Random backpressure when enabled.
   always @(posedge clk) begin
      #1;
      if (sink_rand) begin
         ready_in     = ($urandom_range(0, 3) != 0);
         ready_insert = ($urandom_range(0, 2) != 0);
      end
   end

   // ---------------- source drivers ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_hs(input int src, input bit hdr, output bit ok);
      bit hs;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (rst) return;
         hs = hdr ? (s_valid_insert[src] && s_ready_insert[src]) : (s_valid_in[src] && s_ready_in[src]);
         step();
         if (hs) begin
            ok = 1'b1;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL handshake_timeout src=%0d hdr=%0d: got no handshake required one within 400 cycles", src, hdr);
   endtask

   task automatic drive_beat(input int src, input item_t b);
      sv_in[src] = 1'b1; sd_in[src] = b.data; sk_in[src] = b.keep; sl_in[src] = b.last;
   endtask

   task automatic clear_src(input int src);
      sv_in[src] = 1'b0; sd_in[src] = '0; sk_in[src] = '0; sl_in[src] = 1'b0;
      svi[src]   = 1'b0; sdi[src]   = '0; ski[src]   = '0; sci[src]   = '0;
   endtask

   task automatic send_pkt(input int src, input int nbeats, input logic [DW-1:0] hdr,
                           input logic [BCW-1:0] cnt, input bit early, input int gap_max);
      item_t h;
      item_t b[$];
      item_t x;
      bit    ok;
      h.data = hdr; h.keep = DBW'($urandom); h.cnt = cnt; h.last = 1'b0;
      for (int n = 0; n < nbeats; n++) begin
         x.data = $urandom; x.keep = DBW'($urandom_range(1, 15));
         x.last = (n == nbeats - 1); x.cnt = '0;
         b.push_back(x);
      end
      if (src == 0) begin hq0.push_back(h); foreach (b[i]) bq0.push_back(b[i]); end
      else          begin hq1.push_back(h); foreach (b[i]) bq1.push_back(b[i]); end
      repeat ($urandom_range(0, gap_max)) step();
      svi[src] = 1'b1; sdi[src] = h.data; ski[src] = h.keep; sci[src] = h.cnt;
      if (early) drive_beat(src, b[0]);
      wait_hs(src, 1'b1, ok);
      svi[src] = 1'b0; sdi[src] = '0; ski[src] = '0; sci[src] = '0;
      for (int n = 0; n < nbeats && ok; n++) begin
         if (!(early && n == 0)) begin
            repeat ($urandom_range(0, gap_max)) step();
            drive_beat(src, b[n]);
         end
         wait_hs(src, 1'b0, ok);
         sv_in[src] = 1'b0; sd_in[src] = '0; sk_in[src] = '0; sl_in[src] = 1'b0;
      end
      clear_src(src);
   endtask

   task automatic wait_phase(input mphase_t target, input string name);
      int k = 0;
      while (ph != target && k < 100) begin
         step();
         k++;
      end
      check(name, ph == target, 1);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   logic [DW-1:0] held;
   logic [15:0]   base0, base1;

   initial begin
      rst = 1'b1; sink_rand = 1'b0; ready_in = 1'b1; ready_insert = 1'b1;
      clear_src(0); clear_src(1);
      repeat (3) step();
      rst = 1'b0;
      step();

      // Reset in the middle of a body aborts the packet with no count.
      fork
         send_pkt(0, 4, 32'h1111_0000, 2'd1, 1'b0, 0);
         begin
            wait_phase(M_BODY, "abort_reach_body");
            step();
            rst = 1'b1;
            #1;
            check("abort_busy", busy, 0);
            check("abort_str_out", {valid_in, last_in, keep_in, data_in}, 0);
            check("abort_ready", {s_ready_in, s_ready_insert}, 0);
            check("abort_cnt", {pkt_cnt1, pkt_cnt0}, 0);
            repeat (2) step();
            rst = 1'b0;
         end
      join
      repeat (2) step();

      // Simultaneous requests after reset: source 0 first, then source 1.
      grant_log.delete();
      fork
         send_pkt(0, 3, 32'h0A0A_0001, 2'd3, 1'b0, 0);
         send_pkt(1, 3, 32'h0B0B_0001, 2'd0, 1'b0, 0);
      join
      repeat (2) step();
      check("tie_order_len", grant_log.size(), 2);
      if (grant_log.size() >= 2) begin
         check("tie_first",  grant_log[0], 0);
         check("tie_second", grant_log[1], 1);
      end
      check("tie_cnt0", pkt_cnt0, 16'd1);
      check("tie_cnt1", pkt_cnt1, 16'd1);

      // Lone requester on source 1; header visible one cycle after request.
      fork
         send_pkt(1, 2, 32'hAABB_CCDD, 2'd2, 1'b0, 0);
         begin
            @(negedge clk);
            check("lat_idle_valid", valid_insert, 0);
            @(negedge clk);
            check("lat_valid", valid_insert, 1);
            check("lat_grant", grant, 1);
            check("lat_data",  data_insert, 32'hAABB_CCDD);
            check("lat_cnt",   byte_insert_cnt, 2'd2);
         end
      join
      repeat (2) step();

      // Datapath stalls for 5 cycles mid-body.
      fork
         send_pkt(0, 4, 32'h5151_5151, 2'd1, 1'b0, 0);
         begin
            wait_phase(M_BODY, "stall_reach_body");
            ready_in = 1'b0;
            @(negedge clk);
            held = data_in;
            repeat (5) begin
               check("stall_s_ready_in", s_ready_in, 2'b00);
               check("stall_data_held", {valid_in, data_in}, {1'b1, held});
               check("stall_grant", grant, 0);
               @(negedge clk);
            end
            step();
            ready_in = 1'b1;
         end
      join
      repeat (2) step();

      // Source 0 offers its first beat before the header is accepted.
      fork
         send_pkt(0, 2, 32'hEA71_0000, 2'd0, 1'b1, 0);
         begin
            ready_insert = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check("early_s_ready_in0", s_ready_in[0], 0);
            end
            step();
            ready_insert = 1'b1;
         end
      join
      repeat (2) step();

      // Counter wrap: preload near the top, then two packets.
      force dut.pkt_cnt0 = 16'hFFFE;
      m_cnt[0] = 16'hFFFE;
      step();
      release dut.pkt_cnt0;
      step();
      send_pkt(0, 1, 32'h0000_FFFF, 2'd1, 1'b0, 0);
      repeat (2) step();
      check("wrap_top", pkt_cnt0, 16'hFFFF);
      send_pkt(0, 1, 32'h0001_0000, 2'd1, 1'b0, 0);
      repeat (2) step();
      check("wrap_zero", pkt_cnt0, 16'h0000);

      // Randomized traffic from both sources with random backpressure.
      base0 = pkt_cnt0; base1 = pkt_cnt1;
      sink_rand = 1'b1;
      fork
         for (int p = 0; p < 30; p++)
            send_pkt(0, $urandom_range(1, 5), $urandom, BCW'($urandom), 1'($urandom_range(0, 1)), 3);
         for (int q = 0; q < 30; q++)
            send_pkt(1, $urandom_range(1, 5), $urandom, BCW'($urandom), 1'($urandom_range(0, 1)), 3);
      join
      sink_rand = 1'b0; ready_in = 1'b1; ready_insert = 1'b1;
      repeat (4) step();
      check("rand_pkts0", 16'(pkt_cnt0 - base0), 16'd30);
      check("rand_pkts1", 16'(pkt_cnt1 - base1), 16'd30);
      check("drain_queues", hq0.size() + hq1.size() + bq0.size() + bq1.size(), 0);
      check("final_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_stream_header_arbiter.md
AXI_STREAM_HEADER_ARBITER -- requirements
Module: axi_stream_header_arbiter

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, the stream/header data width in bits.
REQ-002 The block SHALL take parameter DATA_BYTE_WIDTH, default DATA_WIDTH/8, the byte lanes per beat.
REQ-003 The block SHALL take parameter BYTE_CNT_WIDTH, default $clog2(DATA_BYTE_WIDTH), the header byte-count width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be (name direction width meaning), with source i occupying slice i of each s_* vector (i = 0,1):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- s_valid_in  in  2  per-source stream valid
- s_data_in  in  2*DATA_WIDTH  per-source stream data
- s_keep_in  in  2*DATA_BYTE_WIDTH  per-source byte keep
- s_last_in  in  2  per-source end of packet
- s_ready_in  out  2  per-source stream ready
- s_valid_insert  in  2  per-source header valid (the packet request)
- s_data_insert  in  2*DATA_WIDTH  per-source header data
- s_keep_insert  in  2*DATA_BYTE_WIDTH  per-source header keep
- s_byte_insert_cnt  in  2*BYTE_CNT_WIDTH  per-source header byte count
- s_ready_insert  out  2  per-source header ready
- valid_in, data_in, keep_in, last_in  out  1/DATA_WIDTH/DATA_BYTE_WIDTH/1  stream to the header-insert datapath
- ready_in  in  1  datapath stream ready
- valid_insert, data_insert, keep_insert, byte_insert_cnt  out  1/DATA_WIDTH/DATA_BYTE_WIDTH/BYTE_CNT_WIDTH  header to datapath
- ready_insert  in  1  datapath header ready
- busy  out  1  high in HDR or BODY
- grant  out  1  index of the owning source
- pkt_cnt0, pkt_cnt1  out  16 each  completed packets per source, wrapping

Function
REQ-006 The FSM SHALL have states IDLE, HDR, BODY; source i requests when s_valid_insert[i]=1.
REQ-007 In IDLE with any request, the block SHALL register grant (round-robin: on simultaneous requests pick the source not equal to last_grant; else the lone requester) and enter HDR next cycle; no request keeps IDLE.
REQ-008 In HDR, valid_insert/data_insert/keep_insert/byte_insert_cnt SHALL combinationally equal the granted source's header, s_ready_insert[grant]=ready_insert, and on valid_insert&&ready_insert the FSM SHALL enter BODY.
REQ-009 In BODY, valid_in/data_in/keep_in/last_in SHALL combinationally equal the granted source's stream and s_ready_in[grant]=ready_in.
REQ-010 On valid_in&&ready_in&&last_in in BODY the block SHALL return to IDLE, set last_grant<=grant and increment pkt_cnt[grant] (16-bit wrap, 0xFFFF->0x0000).
REQ-011 Ungranted sources, and the granted source outside its phase (stream in HDR, header in BODY), SHALL see ready=0; grant SHALL not change until the last beat handshakes.
REQ-012 Output valids SHALL be 0 and output data/keep/last/byte count 0 whenever not forwarding that channel.
REQ-013 Request-to-header-valid latency SHALL be exactly 1 cycle; one IDLE bubble cycle SHALL separate consecutive packets.
REQ-014 Source valids dropping mid-phase SHALL be forwarded transparently with no state change (pauses permitted).

Reset
REQ-015 While rst=1: state=IDLE, grant=0, last_grant=1 (source 0 wins the first tie), pkt_cnt0=pkt_cnt1=0, busy=0, all readies and output valids 0.
REQ-016 Reset asserted mid-packet SHALL abort the packet immediately, with no count increment.

Verification
REQ-017 Both sources request at once after reset, ready_insert=ready_in=1, 3-beat packets -> source 0 packet, bubble, source 1 packet; pkt_cnt0=pkt_cnt1=1.
REQ-018 Only source 1 requests, header 0xAABBCCDD, byte_insert_cnt=2 -> grant=1, valid_insert high 1 cycle after request with data_insert=0xAABBCCDD.
REQ-019 ready_in=0 for 5 cycles mid-BODY -> s_ready_in=00, output beat held stable, no grant change.
REQ-020 Source 0 streams data beats before its header is accepted -> s_ready_in[0]=0 until HDR handshake.
REQ-021 rst pulsed during BODY -> busy=0, outputs 0, pkt counts unchanged from pre-packet value.
REQ-022 pkt_cnt0 preloaded by 65535 packets, one more -> pkt_cnt0 wraps to 0.
